// File: rtl/ahb_slave_memory_responder_if.sv
// AHB-Lite bundle between a manager (plus decoder/mux) and one memory responder.
// hready is the combined ready returned to every responder on the bus.
interface ahb_slave_memory_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic                    hselx;
  logic [ADDR_WIDTH-1:0]   haddr;
  logic [1:0]              htrans;
  logic                    hwrite;
  logic [2:0]              hsize;
  logic [2:0]              hburst;
  logic [3:0]              hprot;
  logic [DATA_WIDTH-1:0]   hwdata;
  logic [DATA_WIDTH/8-1:0] hwstrb;
  logic                    hready;
  logic                    hreadyout;
  logic                    hresp;
  logic [DATA_WIDTH-1:0]   hrdata;

  modport master (
    output hselx, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hwstrb, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hselx, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hwstrb, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_slave_memory_responder.sv
// AHB-Lite memory responder: byte-addressed storage, WAIT_STATES stall cycles per OKAY transfer,
// two-cycle ERROR for illegal accesses. Define AHB_SLAVE_WSTRB_EN to qualify writes with hwstrb.
module ahb_slave_memory_responder #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_AW      = 12,
  parameter logic [ADDR_WIDTH-1:0] MIN_ADDR    = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] MAX_ADDR    = 32'h0000_0FFF,
  parameter int                    WAIT_STATES = 0
) (
  input logic                         hclk,
  input logic                         hresetn,
  ahb_slave_memory_responder_if.slave bus
);

  localparam int                    NB        = DATA_WIDTH / 8;
  localparam int                    LANE_BITS = $clog2(NB);
  localparam int                    MEM_BYTES = 1 << MEM_AW;
  localparam logic [ADDR_WIDTH-1:0] ADDR_SPAN = MAX_ADDR - MIN_ADDR;
  localparam logic [3:0]            WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

  typedef struct packed {
    logic [1:0]        trans;
    logic              write;
    logic [2:0]        size;
    logic [MEM_AW-1:0] idx;
    logic              legal;
  } aphase_t;

  state_e     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  aphase_t    aphase_q, aphase_d;

  // Address-phase decode. Subtracting MIN_ADDR first lets one unsigned compare
  // catch both below-range (wraps high) and above-range addresses.
  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] align_mask;
  logic                  range_ok, align_ok, size_ok, legal;
  logic                  accept, active;

  assign offset     = bus.haddr - MIN_ADDR;
  assign align_mask = (ADDR_WIDTH'(1) << bus.hsize) - ADDR_WIDTH'(1);
  assign range_ok   = offset <= ADDR_SPAN;
  assign align_ok   = (bus.haddr & align_mask) == '0;
  assign size_ok    = bus.hsize <= 3'(LANE_BITS);
  assign legal      = range_ok & align_ok & size_ok;
  assign accept     = bus.hselx & bus.hready;
  assign active     = accept & bus.htrans[1];

  // Bytes covered by a transfer of 2**size bytes starting at lane 'low'.
  function automatic logic [NB-1:0] lane_mask(input logic [2:0] size,
                                              input logic [LANE_BITS-1:0] low);
    logic [NB-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) m[i] = (i < (1 << size));
    return m << low;
  endfunction

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      aphase_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      aphase_q   <= aphase_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    aphase_d   = aphase_q;
    case (state_q)
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) state_d = ST_DATA;
        else                    wait_cnt_d = wait_cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all complete with hreadyout high, so the next address phase lands here.
        state_d = ST_IDLE;
        if (accept) begin
          aphase_d = '{trans: bus.htrans, write: bus.hwrite, size: bus.hsize,
                       idx: offset[MEM_AW-1:0], legal: legal};
        end
        if (active) begin
          if (!legal) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
    endcase
  end

  // Storage access for the registered address phase.
  logic [7:0]                  mem [MEM_BYTES];
  logic [MEM_AW-LANE_BITS-1:0] row;
  logic [NB-1:0]               lane_en, byte_en;
  logic [DATA_WIDTH-1:0]       rd_word;
  logic                        wr_en;

  assign row     = aphase_q.idx[MEM_AW-1:LANE_BITS];
  assign lane_en = lane_mask(aphase_q.size, aphase_q.idx[LANE_BITS-1:0]);
`ifdef AHB_SLAVE_WSTRB_EN
  assign byte_en = lane_en & bus.hwstrb;
`else
  assign byte_en = lane_en;
`endif
  assign wr_en   = (state_q == ST_DATA) && aphase_q.write && aphase_q.legal && aphase_q.trans[1];

  always_comb begin
    for (int l = 0; l < NB; l++) rd_word[8*l +: 8] = mem[{row, LANE_BITS'(l)}];
  end

  // NOTE: storage is deliberately not reset; only control state is cleared by hresetn.
  always_ff @(posedge hclk) begin
    if (wr_en) begin
      for (int l = 0; l < NB; l++) begin
        if (byte_en[l]) mem[{row, LANE_BITS'(l)}] <= bus.hwdata[8*l +: 8];
      end
    end
  end

  always_comb begin
    bus.hreadyout = 1'b1;
    bus.hresp     = 1'b0;
    bus.hrdata    = '0;
    case (state_q)
      ST_WAIT: bus.hreadyout = 1'b0;
      ST_ERR1: begin
        bus.hreadyout = 1'b0;
        bus.hresp     = 1'b1;
      end
      ST_ERR2: bus.hresp = 1'b1;
      ST_DATA: if (!aphase_q.write) bus.hrdata = rd_word;
      default: ;
    endcase
  end

  // hburst/hprot are informational; trans[0] only distinguishes NONSEQ from SEQ.
  logic unused_ok;
`ifdef AHB_SLAVE_WSTRB_EN
  assign unused_ok = ^{bus.hburst, bus.hprot, aphase_q.trans[0]};
`else
  assign unused_ok = ^{bus.hburst, bus.hprot, bus.hwstrb, aphase_q.trans[0]};
`endif

endmodule

// File: tb/tb_ahb_slave_memory_responder.sv
// Self-checking bench: a driver issues AHB transfers and queues expected responses computed
// from a byte-array model; a monitor compares every data-phase cycle against the queue.
module tb_ahb_slave_memory_responder;

  localparam int          WAIT  = 2;
  localparam logic [31:0] MAX_A = 32'h0000_0FFF;
  localparam logic [1:0]  T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0]  SZ_B = 3'd0, SZ_H = 3'd1, SZ_W = 3'd2;
  localparam logic [2:0]  B_SINGLE = 3'd0, B_INCR4 = 3'd3;
`ifdef AHB_SLAVE_WSTRB_EN
  localparam bit STRB_EN = 1'b1;
`else
  localparam bit STRB_EN = 1'b0;
`endif

  typedef enum {K_IDLE, K_OKAY, K_ERR} kind_e;
  typedef struct {
    kind_e       kind;
    logic        is_read;
    logic [31:0] rdata;
    int          acc_cyc;
  } exp_t;

  logic hclk    = 1'b0;
  logic hresetn = 1'b1;
  always #5 hclk = ~hclk;

  ahb_slave_memory_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  assign bus.hready = bus.hreadyout;

  ahb_slave_memory_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_AW(12),
    .MIN_ADDR(32'h0000_0000), .MAX_ADDR(MAX_A), .WAIT_STATES(WAIT)
  ) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  exp_t        sb_q[$];
  logic [7:0]  ref_mem [4096];
  logic [31:0] pend_wdata;
  logic [3:0]  pend_strb;

  always @(posedge hclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] resp_word();
    return 64'({bus.hreadyout, bus.hresp, bus.hrdata});
  endfunction

  function automatic logic [63:0] exp_word(input logic rdy, input logic rsp, input logic [31:0] d);
    return 64'({rdy, rsp, d});
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [11:0] b;
    b = {a[11:2], 2'b00};
    return {ref_mem[b + 12'd3], ref_mem[b + 12'd2], ref_mem[b + 12'd1], ref_mem[b]};
  endfunction

  // Each addressed byte comes from the bus lane equal to its address modulo 4.
  task automatic ref_write(input logic [31:0] a, input logic [2:0] size,
                           input logic [31:0] wdata, input logic [3:0] strb);
    logic [31:0] ba;
    for (int k = 0; k < (1 << size); k++) begin
      ba = a + 32'(k);
      if (!STRB_EN || strb[ba[1:0]]) ref_mem[ba[11:0]] = wdata[8*ba[1:0] +: 8];
    end
  endtask

  task automatic issue(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [2:0] burst, input bit commit);
    exp_t e;
    bit   active, legal;
    int   stall;
    stall = 0;
    @(negedge hclk);
    while (bus.hreadyout !== 1'b1) begin
      stall++;
      if (stall > 40) begin
        check("ready_timeout", 64'(bus.hreadyout), 64'd1);
        break;
      end
      @(negedge hclk);
    end
    bus.hselx  = sel;
    bus.htrans = trans;
    bus.hwrite = wr;
    bus.hsize  = size;
    bus.haddr  = addr;
    bus.hburst = burst;
    bus.hprot  = 4'($urandom);
    bus.hwdata = pend_wdata;
    bus.hwstrb = pend_strb;
    pend_wdata = wr ? wdata : $urandom;
    pend_strb  = strb;
    active = sel && trans[1];
    legal  = (addr <= MAX_A) && ((addr % (32'd1 << size)) == 32'd0) && (size <= SZ_W);
    e.acc_cyc = cyc + 1;
    e.is_read = !wr;
    e.rdata   = 32'd0;
    if (!active)     e.kind = K_IDLE;
    else if (!legal) e.kind = K_ERR;
    else begin
      e.kind = K_OKAY;
      if (wr) begin
        if (commit) ref_write(addr, size, wdata, strb);
      end else begin
        e.rdata = ref_read(addr);
      end
    end
    sb_q.push_back(e);
  endtask

  always @(negedge hclk) begin : monitor
    exp_t e;
    int   n;
    if (hresetn && sb_q.size() > 0 && sb_q[0].acc_cyc <= cyc) begin
      e = sb_q[0];
      n = cyc - e.acc_cyc;
      case (e.kind)
        K_IDLE: begin
          check("idle_okay", resp_word(), exp_word(1'b1, 1'b0, 32'd0));
          void'(sb_q.pop_front());
        end
        K_OKAY: begin
          if (n < WAIT) begin
            check("wait_state", resp_word(), exp_word(1'b0, 1'b0, 32'd0));
          end else begin
            check("okay_data", resp_word(), exp_word(1'b1, 1'b0, e.is_read ? e.rdata : 32'd0));
            void'(sb_q.pop_front());
          end
        end
        default: begin
          if (n == 0) begin
            check("err_first", resp_word(), exp_word(1'b0, 1'b1, 32'd0));
          end else begin
            check("err_second", resp_word(), exp_word(1'b1, 1'b1, 32'd0));
            void'(sb_q.pop_front());
          end
        end
      endcase
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bus.hselx  = 1'b0;
    bus.htrans = T_IDLE;
    bus.hwrite = 1'b0;
    bus.hsize  = SZ_W;
    bus.haddr  = 32'd0;
    bus.hburst = B_SINGLE;
    bus.hprot  = 4'd0;
    bus.hwdata = 32'd0;
    bus.hwstrb = 4'd0;
    pend_wdata = 32'd0;
    pend_strb  = 4'd0;

    #1 hresetn = 1'b0;
    repeat (3) @(negedge hclk);
    check("reset_state", resp_word(), exp_word(1'b1, 1'b0, 32'd0));
    hresetn = 1'b1;
    @(negedge hclk);
    check("post_reset", resp_word(), exp_word(1'b1, 1'b0, 32'd0));

    // Preload the region used by random traffic so every read has a known answer.
    for (int a = 0; a < 256; a += 4)
      issue(1'b1, T_NSEQ, 1'b1, SZ_W, 32'(a), $urandom, 4'hF, B_SINGLE, 1'b1);

    // Write then read back-to-back.
    issue(1'b1, T_NSEQ, 1'b1, SZ_W, 32'h10, 32'hDEAD_BEEF, 4'hF, B_SINGLE, 1'b1);
    issue(1'b1, T_NSEQ, 1'b0, SZ_W, 32'h10, 32'd0, 4'hF, B_SINGLE, 1'b1);

    // INCR4 write then INCR4 read.
    for (int i = 0; i < 4; i++)
      issue(1'b1, (i == 0) ? T_NSEQ : T_SEQ, 1'b1, SZ_W, 32'h20 + 32'(4*i), 32'(i+1), 4'hF, B_INCR4, 1'b1);
    for (int i = 0; i < 4; i++)
      issue(1'b1, (i == 0) ? T_NSEQ : T_SEQ, 1'b0, SZ_W, 32'h20 + 32'(4*i), 32'd0, 4'hF, B_INCR4, 1'b1);

    // Illegal accesses, IDLE during the second ERROR cycle, then storage still intact.
    issue(1'b1, T_NSEQ, 1'b0, SZ_W, 32'h1000, 32'd0, 4'hF, B_SINGLE, 1'b1);
    issue(1'b1, T_IDLE, 1'b0, SZ_W, 32'h0, 32'd0, 4'hF, B_SINGLE, 1'b1);
    issue(1'b1, T_NSEQ, 1'b1, SZ_W, 32'h1004, 32'h5555_5555, 4'hF, B_SINGLE, 1'b1);
    issue(1'b1, T_NSEQ, 1'b1, SZ_W, 32'h42, 32'hFFFF_FFFF, 4'hF, B_SINGLE, 1'b1);
    issue(1'b1, T_NSEQ, 1'b1, SZ_H, 32'h45, 32'hFFFF_FFFF, 4'hF, B_SINGLE, 1'b1);
    issue(1'b1, T_NSEQ, 1'b1, 3'd3, 32'h48, 32'hFFFF_FFFF, 4'hF, B_SINGLE, 1'b1);
    issue(1'b1, T_BUSY, 1'b0, SZ_W, 32'h10, 32'd0, 4'hF, B_SINGLE, 1'b1);
    issue(1'b1, T_NSEQ, 1'b0, SZ_W, 32'h10, 32'd0, 4'hF, B_SINGLE, 1'b1);
    issue(1'b1, T_NSEQ, 1'b0, SZ_W, 32'h44, 32'd0, 4'hF, B_SINGLE, 1'b1);

    // Byte lane placement, halfword, and an all-zero strobe word write.
    issue(1'b1, T_NSEQ, 1'b1, SZ_W, 32'h40, 32'h0, 4'hF, B_SINGLE, 1'b1);
    issue(1'b1, T_NSEQ, 1'b1, SZ_B, 32'h41, 32'h1122_AB44, 4'hF, B_SINGLE, 1'b1);
    issue(1'b1, T_NSEQ, 1'b0, SZ_W, 32'h40, 32'd0, 4'hF, B_SINGLE, 1'b1);
    issue(1'b1, T_NSEQ, 1'b1, SZ_H, 32'h4A, 32'h7788_9900, 4'hF, B_SINGLE, 1'b1);
    issue(1'b1, T_NSEQ, 1'b0, SZ_W, 32'h48, 32'd0, 4'hF, B_SINGLE, 1'b1);
    issue(1'b1, T_NSEQ, 1'b1, SZ_W, 32'h40, 32'hFFFF_FFFF, 4'h0, B_SINGLE, 1'b1);
    issue(1'b1, T_NSEQ, 1'b0, SZ_W, 32'h40, 32'd0, 4'hF, B_SINGLE, 1'b1);

    // Reset during the wait states of a write: the write must be abandoned.
    issue(1'b1, T_NSEQ, 1'b1, SZ_W, 32'h80, 32'hCAFE_F00D, 4'hF, B_SINGLE, 1'b0);
    @(negedge hclk);
    #2 hresetn = 1'b0;
    sb_q.delete();
    #1 check("reset_mid_wait", resp_word(), exp_word(1'b1, 1'b0, 32'd0));
    bus.hselx  = 1'b0;
    bus.htrans = T_IDLE;
    pend_wdata = 32'd0;
    pend_strb  = 4'd0;
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;
    issue(1'b1, T_NSEQ, 1'b0, SZ_W, 32'h80, 32'd0, 4'hF, B_SINGLE, 1'b1);

    // Random mix of legal, illegal, idle and deselected transfers.
    for (int t = 0; t < 300; t++) begin
      int          r;
      logic [2:0]  s;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      s = 3'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 63)) * 4 + ((32'($urandom_range(0, 3)) >> s) << s);
      case (r)
        0: issue(1'b0, 2'($urandom), 1'($urandom), s, a, $urandom, 4'($urandom), 3'($urandom), 1'b1);
        1: issue(1'b1, 2'($urandom_range(0, 1)), 1'($urandom), s, a, $urandom, 4'($urandom), 3'($urandom), 1'b1);
        2, 3, 4: issue(1'b1, $urandom_range(0, 1) ? T_NSEQ : T_SEQ, 1'b1, s, a, $urandom,
                       4'($urandom), 3'($urandom), 1'b1);
        8: begin
          case ($urandom_range(0, 2))
            0: begin a = 32'h1000 + 32'($urandom_range(0, 255)) * 4; s = SZ_W; end
            1: begin a = {a[31:2], 2'($urandom_range(1, 3))}; s = SZ_W; end
            default: begin a = {a[31:3], 3'b000}; s = 3'd3 + 3'($urandom_range(0, 4)); end
          endcase
          issue(1'b1, T_NSEQ, 1'($urandom), s, a, $urandom, 4'($urandom), 3'($urandom), 1'b1);
        end
        default: issue(1'b1, $urandom_range(0, 1) ? T_NSEQ : T_SEQ, 1'b0, s, a, 32'd0,
                       4'($urandom), 3'($urandom), 1'b1);
      endcase
    end

    repeat (3) issue(1'b0, T_IDLE, 1'b0, SZ_W, 32'd0, 32'd0, 4'd0, B_SINGLE, 1'b1);
    repeat (WAIT + 4) @(negedge hclk);
    check("scoreboard_drain", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
